// File: rtl/rol_seq.sv
// Sequential rotate-left unit with valid/ready handshakes.
// Optional ROL_FAST_EN build replaces the one-bit-per-clock loop with a single-cycle barrel rotate.
module rol_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_bits,
  input  logic             k1,
  input  logic             k2,
  output logic [WIDTH-1:0] output_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

`ifdef ROL_FAST_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;
`endif

  localparam int MAX_STEPS = (2 ** AMT_W) - 1;

  state_t           state_r;
  logic [AMT_W-1:0] amt_s;

  assign amt_s = {k1, k2};

  // Amounts >= WIDTH still take single-bit steps, so the result is amount mod WIDTH.
  function automatic logic [WIDTH-1:0] rol_amt(input logic [WIDTH-1:0] w,
                                               input logic [AMT_W-1:0] a);
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < MAX_STEPS; i++) begin
      if (i < int'(a)) begin
        r = {r[WIDTH-2:0], r[WIDTH-1]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

`ifdef ROL_FAST_EN
  // Control FSM and registered outputs: barrel rotate registered on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      output_bits <= {WIDTH{1'b0}};
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            output_bits <= rol_amt(input_bits, amt_s);
            state_r     <= DONE;
            out_valid   <= 1'b1;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
`else
  logic [WIDTH-1:0] data_r;
  logic [AMT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rot1_s;

  assign rot1_s = rol_amt(data_r, AMT_W'(1));

  // Control FSM and registered outputs: one rotation per clock while in ROT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      data_r      <= {WIDTH{1'b0}};
      cnt_r       <= {AMT_W{1'b0}};
      output_bits <= {WIDTH{1'b0}};
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r   <= input_bits;
            cnt_r    <= amt_s;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (amt_s == {AMT_W{1'b0}}) begin
              state_r     <= DONE;
              output_bits <= input_bits;
              out_valid   <= 1'b1;
            end else begin
              state_r <= ROT;
            end
          end
        end
        ROT: begin
          data_r <= rot1_s;
          cnt_r  <= cnt_r - AMT_W'(1);
          // Result is published on the last step so it is stable for the whole DONE phase.
          if (cnt_r == AMT_W'(1)) begin
            state_r     <= DONE;
            output_bits <= rot1_s;
            out_valid   <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= {AMT_W{1'b0}};
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule
